hex_display_driver: RTL and testbench
=====================================

Name: hex_display_driver

Overview:
- Multi-digit hexadecimal seven-segment driver for the board HEX displays.
- Accepts an N-digit value over a valid/ready handshake and registers it. Decodes each nibble to active-low segments.
- Adds per-digit blink with an internal prescaler and a registered output stage, so the HEX pins are glitch-free.
- Sits between lab datapaths (counters, ALUs, FSM state) and the HEX pins.

Parameters:
- NUM_DIGITS, 6, number of displays driven (1..8).
- BLINK_DIV, 25000000, clock cycles per blink half-period (>=2).
- CNT_W, 25, prescaler counter width; must satisfy 2^CNT_W >= BLINK_DIV.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- in_valid  in  1  in_value/in_blink are presented.
- in_ready  out  1  block can accept a new value.
- in_value  in  4*NUM_DIGITS  digit i = in_value[4i+3:4i]; digit 0 is rightmost.
- in_blink  in  NUM_DIGITS  per-digit blink enable, captured with in_value.
- blank  in  1  level input; all segments off while high. Not registered with the handshake.
- hex_out  out  7*NUM_DIGITS  digit i = hex_out[7i+6:7i]; bit 0 = segment a … bit 6 = segment g; active-low.

Behaviour:
- Reset (resetn=0, asynchronous):
  - value_q=0, blink_q=0, prescaler=0, phase=0, state=IDLE.
  - in_ready=1.
  - hex_out = all ones (all segments off).
- States:
  - IDLE: in_ready=1. On in_valid&in_ready at a rising edge, value_q<=in_value and blink_q<=in_blink, then go to UPDATE.
  - UPDATE: in_ready=0 for exactly one cycle. The decode stage is registered into hex_out at the end of this cycle, then return to IDLE.
- Latency: accepted at edge N; new segments visible on hex_out after edge N+1.
- Throughput: one value per 2 cycles. in_valid held high during UPDATE is ignored and is not captured twice.
- Decode table, active-low with segments abcdefg listed as bit0..bit6:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
  - These are listed as bit6..bit0, i.e. the hex_out digit-slice value.
- Prescaler:
  - Free-runs from reset. Counts 0..BLINK_DIV-1, then wraps to 0 and toggles phase.
  - Not reset by loads.
- hex_out is re-registered every cycle in IDLE as well, so blink and blank act continuously:
  - digit i = 7'h7F if blank, or (blink_q[i] & phase); otherwise decode(value_q digit i).
- blank has 1-cycle latency to hex_out.
- Simultaneous events:
  - Load and phase toggle in the same cycle: both apply; the new value is shown with the new phase.
  - resetn asserted mid-UPDATE: abort to IDLE and apply reset values; the pending value is lost.
- in_value is only sampled on the accept edge; changes at any other time have no effect.

Optional Feature:
- Macro: HEX_LEADING_ZERO_BLANK_EN.
- When defined:
  - Input zlb_enable (1 bit) is added.
  - When zlb_enable=1, zero digits above the most-significant non-zero digit are blanked (7'h7F).
  - Digit 0 is always shown, so a value of 0 displays a single "0".
  - The blank mask is computed from value_q and registered with hex_out; latency is unchanged.
- When not defined: no extra port; all digits are always shown.

Decomposition:
- Package hex_display_pkg:
  - SEG_W=7.
  - SEG_OFF=7'h7F.
  - 16-entry segment pattern constant array.
  - State encoding: IDLE=1'b0, UPDATE=1'b1.
- Sub-module hex_seg_decoder: combinational 4-bit to 7-bit lookup using the package table. Instantiated NUM_DIGITS times in a generate loop.
- Prescaler, FSM and output register stay in the top level.

Test Plan (NUM_DIGITS=6, BLINK_DIV=4 for sim):
- Reset:
  - Stimulus: resetn low for 3 cycles, then released.
  - Response: hex_out=42'h3FF_FFFF_FFFF and in_ready=1 throughout.
- Load and latency:
  - Stimulus: load 24'h0123AF in 1 cycle.
  - Response: in_ready low for exactly 1 cycle. After edge N+1, digits 0..5 read 0001110, 0001000, 0110000, 0100100, 1111001, 1000000 (bit6..bit0).
- Back-to-back loads:
  - Stimulus: in_valid held high for 4 cycles with values 24'h111111, 24'h222222, 24'h333333, 24'h444444.
  - Response: only the values presented on accept edges are taken, i.e. 1st and 3rd. Display ends at 24'h333333.
- Blink:
  - Stimulus: in_blink=6'b000001 with value 24'h000005.
  - Response: digit 0 alternates 0010010 / 7'h7F every 4 cycles. Other digits stay steady at 1000000.
- Blank and reset:
  - Stimulus: blank=1 for 5 cycles, then resetn pulsed low asynchronously between edges.
  - Response: hex_out goes all ones 1 cycle after blank rises. On reset it goes all ones immediately, without waiting for a clock edge.
- Optional feature (HEX_LEADING_ZERO_BLANK_EN, zlb_enable=1):
  - Load 24'h000A00: digits 5..3 blank, digits 2..0 show A,0,0.
  - Load 24'h000000: only digit 0 shows 1000000.

Source files
------------

// File: rtl/hex_display_pkg.sv
// Shared types and constants for the hex display driver.
// Segment table is active-low, bit0 = a ... bit6 = g.
package hex_display_pkg;

    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;

    localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic {
        IDLE   = 1'b0,
        UPDATE = 1'b1
    } state_t;

endpackage

// File: rtl/hex_seg_decoder.sv
// Nibble to active-low seven-segment lookup.
// Purely combinational; the top registers the result.
module hex_seg_decoder
    import hex_display_pkg::*;
(
    input  logic [3:0]       i_nibble,
    output logic [SEG_W-1:0] o_seg
);

    assign o_seg = SEG_TABLE[i_nibble];

endmodule

// File: rtl/hex_display_driver.sv
// Multi-digit hex seven-segment driver with blink, blank and
// registered outputs. Optional HEX_LEADING_ZERO_BLANK_EN adds zlb_enable.
module hex_display_driver
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_DIV  = 25000000,
    parameter int CNT_W      = 25
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [4*NUM_DIGITS-1:0]     in_value,
    input  logic [NUM_DIGITS-1:0]       in_blink,
    input  logic                        blank,
`ifdef HEX_LEADING_ZERO_BLANK_EN
    input  logic                        zlb_enable,
`endif
    output logic [SEG_W*NUM_DIGITS-1:0] hex_out
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

    state_t                        r_state;
    logic                          r_ready;
    logic [4*NUM_DIGITS-1:0]       r_value;
    logic [NUM_DIGITS-1:0]         r_blink;
    logic [CNT_W-1:0]              r_cnt;
    logic                          r_phase;
    logic [SEG_W*NUM_DIGITS-1:0]   r_hex;
    logic [SEG_W*NUM_DIGITS-1:0]   w_dec;
    logic [SEG_W*NUM_DIGITS-1:0]   w_hex_next;
    logic [NUM_DIGITS-1:0]         w_off;

    genvar g;
    generate
        for (g = 0; g < NUM_DIGITS; g++) begin : g_dec
            hex_seg_decoder u_dec (
                .i_nibble (r_value[4*g +: 4]),
                .o_seg    (w_dec[SEG_W*g +: SEG_W])
            );
        end
    endgenerate

`ifdef HEX_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] w_zmask;
    logic                  w_seen;

    // Blank zero digits above the most-significant non-zero digit.
    always_comb begin
        w_zmask = '0;
        w_seen  = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (r_value[4*i +: 4] != 4'h0) begin
                w_seen = 1'b1;
            end
            w_zmask[i] = zlb_enable & ~w_seen;
        end
    end
`endif

    // Per-digit off mask from blank, blink phase and zero blanking.
    always_comb begin
        w_off = {NUM_DIGITS{blank}} | (r_blink & {NUM_DIGITS{r_phase}});
`ifdef HEX_LEADING_ZERO_BLANK_EN
        w_off = w_off | w_zmask;
`endif
        w_hex_next = w_dec;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_off[i]) begin
                w_hex_next[SEG_W*i +: SEG_W] = SEG_OFF;
            end
        end
    end

    // Load handshake: accept in IDLE, spend one UPDATE cycle busy.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_value <= '0;
            r_blink <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_value <= in_value;
                        r_blink <= in_blink;
                        r_state <= UPDATE;
                        r_ready <= 1'b0;
                    end
                end
                UPDATE: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    // Free-running blink prescaler; phase flips on each wrap.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (r_cnt == CNT_MAX) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    // Output register refreshed every cycle for glitch-free pins.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hex <= '1;
        end else begin
            r_hex <= w_hex_next;
        end
    end

    assign in_ready = r_ready;
    assign hex_out  = r_hex;

endmodule

// File: tb/tb_hex_display_driver.sv
// Directed self-checking bench for hex_display_driver.
// Define HEX_LEADING_ZERO_BLANK_EN to also exercise zero blanking.
module tb_hex_display_driver;

    localparam int ND = 6;
    localparam int BD = 4;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [23:0]   in_value = '0;
    logic [5:0]    in_blink = '0;
    logic          blank = 1'b0;
    logic [41:0]   hex_out;
`ifdef HEX_LEADING_ZERO_BLANK_EN
    logic          zlb_enable = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [41:0] ALL_OFF = {42{1'b1}};
    localparam logic [41:0] ZEROS   = {6{7'h40}};

    hex_display_driver #(
        .NUM_DIGITS (ND),
        .BLINK_DIV  (BD),
        .CNT_W      (CW)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_value   (in_value),
        .in_blink   (in_blink),
        .blank      (blank),
`ifdef HEX_LEADING_ZERO_BLANK_EN
        .zlb_enable (zlb_enable),
`endif
        .hex_out    (hex_out)
    );

    always #5 clk = ~clk;

    // Reference blink phase: counts 0..BD-1, toggles on wrap.
    logic [1:0] m_cnt;
    logic       m_phase;
    logic       m_prev;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_cnt   <= '0;
            m_phase <= 1'b0;
            m_prev  <= 1'b0;
        end else begin
            m_prev <= m_phase;
            if (m_cnt == 2'd3) begin
                m_cnt   <= '0;
                m_phase <= ~m_phase;
            end else begin
                m_cnt <= m_cnt + 2'd1;
            end
        end
    end

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_hex", 64'(hex_out), 64'(ALL_OFF));
            check("rst_rdy", 64'(in_ready), 64'd1);
        end
        resetn = 1'b1;
        step();
        check("post_rst_hex", 64'(hex_out), 64'(ZEROS));

        // Single load and latency
        in_value = 24'h0123AF;
        in_valid = 1'b1;
        step();
        check("ld_rdy_low", 64'(in_ready), 64'd0);
        check("ld_hex_old", 64'(hex_out), 64'(ZEROS));
        in_valid = 1'b0;
        in_value = 24'hFFFFFF;
        step();
        check("ld_rdy_high", 64'(in_ready), 64'd1);
        check("ld_hex_new", 64'(hex_out),
              64'({7'h40, 7'h79, 7'h24, 7'h30, 7'h08, 7'h0E}));
        step();
        check("ld_no_resample", 64'(hex_out),
              64'({7'h40, 7'h79, 7'h24, 7'h30, 7'h08, 7'h0E}));

        // Back-to-back: valid held for four cycles
        in_valid = 1'b1;
        in_value = 24'h111111;
        step();
        check("b2b_rdy0", 64'(in_ready), 64'd0);
        in_value = 24'h222222;
        step();
        check("b2b_rdy1", 64'(in_ready), 64'd1);
        check("b2b_hex1", 64'(hex_out), 64'({6{7'h79}}));
        in_value = 24'h333333;
        step();
        check("b2b_rdy2", 64'(in_ready), 64'd0);
        check("b2b_hex2", 64'(hex_out), 64'({6{7'h79}}));
        in_value = 24'h444444;
        step();
        check("b2b_rdy3", 64'(in_ready), 64'd1);
        check("b2b_hex3", 64'(hex_out), 64'({6{7'h30}}));
        in_valid = 1'b0;
        step();
        check("b2b_final", 64'(hex_out), 64'({6{7'h30}}));

        // Blink on digit 0
        in_value = 24'h000005;
        in_blink = 6'b000001;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_blink = '0;
        for (int i = 0; i < 16; i++) begin
            step();
            check("blink_d0", 64'(hex_out[6:0]),
                  64'(m_prev ? 7'h7F : 7'h12));
            check("blink_hi", 64'(hex_out[41:7]), 64'({5{7'h40}}));
        end

        // Blank with one-cycle latency
        blank = 1'b1;
        #1;
        check("blank_lat", 64'(hex_out[41:7]), 64'({5{7'h40}}));
        for (int i = 0; i < 5; i++) begin
            step();
            check("blank_on", 64'(hex_out), 64'(ALL_OFF));
        end
        blank = 1'b0;
        step();
        check("blank_off_hi", 64'(hex_out[41:7]), 64'({5{7'h40}}));
        check("blank_off_d0", 64'(hex_out[6:0]),
              64'(m_prev ? 7'h7F : 7'h12));

        // Asynchronous reset in the middle of UPDATE
        in_value = 24'h777777;
        in_valid = 1'b1;
        step();
        check("upd_rdy", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        #3;
        resetn = 1'b0;
        #1;
        check("arst_hex", 64'(hex_out), 64'(ALL_OFF));
        check("arst_rdy", 64'(in_ready), 64'd1);
        @(negedge clk);
        resetn = 1'b1;
        step();
        check("arst_lost", 64'(hex_out), 64'(ZEROS));

`ifdef HEX_LEADING_ZERO_BLANK_EN
        zlb_enable = 1'b1;
        in_value   = 24'h000A00;
        in_valid   = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check("zlb_a00", 64'(hex_out),
              64'({7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h40, 7'h40}));
        in_value = 24'h000000;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check("zlb_zero", 64'(hex_out), 64'({{5{7'h7F}}, 7'h40}));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
